// File: rtl/q88_mult_mag_seq.sv
// q88_mult_mag_seq: iterative signed Q8.8 multiplier producing rounded, saturated magnitude plus sign
module q88_mult_mag_seq #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] mag,
  output logic         neg,
  output logic         sat
);
  localparam logic [2:0] IDLE = 3'd0, ABS = 3'd1, MUL = 3'd2, NORM = 3'd3, DONE = 3'd4;
  logic [2:0]     state;
  logic [W-1:0]   ra, rb, mb, lim, res;
  logic [2*W-1:0] p, mx, r;
  logic [4:0]     cnt;
  logic           s, ovf;
  // the 32-bit rounding add cannot overflow since |a|*|b| <= 2^30
  always_comb begin
    r    = (p + ((2*W)'(1) << (FRAC - 1))) >> FRAC;
    lim  = s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    ovf  = r > {{W{1'b0}}, lim};
    res  = ovf ? lim : r[W-1:0];
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      mb    <= '0;
      mx    <= '0;
      p     <= '0;
      cnt   <= '0;
      s     <= 1'b0;
      mag   <= '0;
      neg   <= 1'b0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          state <= ABS;
        end
        ABS: begin
          mx    <= {{W{1'b0}}, ra[W-1] ? -ra : ra};
          mb    <= rb[W-1] ? -rb : rb;
          s     <= ra[W-1] ^ rb[W-1];
          p     <= '0;
          cnt   <= '0;
          state <= MUL;
        end
        MUL: begin
          // one multiplier bit per cycle, LSB first; the cycle with cnt==W only hands off
          if (cnt != 5'(W)) begin
            if (mb[0]) p <= p + mx;
            mx <= mx << 1;
            mb <= mb >> 1;
          end
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'(W) ? NORM : MUL;
        end
        NORM: begin
          mag   <= res;
          sat   <= ovf;
          neg   <= s & (res != '0);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_q88_mult_mag_seq.sv
// tb_q88_mult_mag_seq: scoreboard bench for the iterative Q8.8 magnitude multiplier
module tb_q88_mult_mag_seq;
  typedef struct packed {
    logic [15:0] mag;
    logic        neg;
    logic        sat;
  } res_t;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, neg, sat;
  logic [15:0] mag;
  int          n_chk = 0, n_fail = 0, done_cnt = 0;
  res_t        sb[$];
  q88_mult_mag_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .mag(mag), .neg(neg), .sat(sat)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    res_t   o;
    longint prod, m, r, lim;
    prod = longint'($signed(x)) * longint'($signed(y));
    m    = prod < 0 ? -prod : prod;
    r    = (m + 128) / 256;
    lim  = (x[15] ^ y[15]) ? 32768 : 32767;
    o.sat = r > lim;
    o.mag = o.sat ? 16'(lim) : 16'(r);
    o.neg = (x[15] ^ y[15]) && o.mag != 0;
    return o;
  endfunction
  // drives one operation (optionally injecting a second start inj cycles in) and waits for done
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int inj,
                        output int lat, output res_t got, output logic done_next);
    sb.push_back(model(x, y));
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (inj != 0 && lat == inj) begin
        a = 16'h7FFF; b = 16'h8001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat++;
      end
    end
    got = {mag, neg, sat};
    @(posedge clk);
    #1 done_next = done;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, mag, neg, sat} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b mag=%h neg=%b sat=%b, expected all zero", busy, done, mag, neg, sat);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_vectors;
    logic [15:0] va[8] = '{16'h0180, 16'hFE80, 16'h8000, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 16'hFF00};
    logic [15:0] vb[8] = '{16'h0200, 16'h0200, 16'h0100, 16'hFF00, 16'h7FFF, 16'h0080, 16'hFF00, 16'hFF00};
    res_t        fixed[8] = '{'{16'h0300, 1'b0, 1'b0}, '{16'h0300, 1'b1, 1'b0}, '{16'h8000, 1'b1, 1'b0},
                              '{16'h7FFF, 1'b0, 1'b1}, '{16'h7FFF, 1'b0, 1'b1}, '{16'h0001, 1'b0, 1'b0},
                              '{16'h0000, 1'b0, 1'b0}, '{16'h0100, 1'b0, 1'b0}};
    int   lat;
    res_t got, exp;
    logic dn;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], 0, lat, got, dn);
      exp = sb.pop_front();
      n_chk += 3;
      if (lat !== 19) begin
        n_fail++;
        $display("FAIL vec%0d latency: got %0d, expected 19", i, lat);
      end
      if (got !== exp || got !== fixed[i]) begin
        n_fail++;
        $display("FAIL vec%0d result: got mag=%h neg=%b sat=%b, expected mag=%h neg=%b sat=%b",
                 i, got.mag, got.neg, got.sat, fixed[i].mag, fixed[i].neg, fixed[i].sat);
      end
      if (dn !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d done width: done still %b one cycle later, expected 0", i, dn);
      end
    end
    repeat (3) @(posedge clk);
    #1 n_chk++;
    if (mag !== 16'h0100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: mag=%h busy=%b, expected mag=0100 busy=0", mag, busy);
    end
  endtask
  task automatic test_back_to_back;
    int   lat;
    res_t got, exp;
    logic dn;
    for (int i = 0; i < 10; i++) begin
      run_op(16'($urandom), 16'($urandom), 0, lat, got, dn);
      exp = sb.pop_front();
      n_chk++;
      if (lat !== 19 || got !== exp) begin
        n_fail++;
        $display("FAIL b2b%0d: lat=%0d mag=%h neg=%b sat=%b, expected lat=19 mag=%h neg=%b sat=%b",
                 i, lat, got.mag, got.neg, got.sat, exp.mag, exp.neg, exp.sat);
      end
    end
  endtask
  task automatic test_ignore_start;
    int   lat, d0;
    res_t got, exp;
    logic dn;
    d0 = done_cnt;
    run_op(16'h0180, 16'h0200, 6, lat, got, dn);
    exp = sb.pop_front();
    repeat (25) @(posedge clk);
    #1 n_chk += 2;
    if (lat !== 19 || got !== exp) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d mag=%h neg=%b sat=%b, expected lat=19 mag=%h neg=%b sat=%b",
               lat, got.mag, got.neg, got.sat, exp.mag, exp.neg, exp.sat);
    end
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start pulses: %0d done pulses busy=%b, expected 1 pulse busy=0", done_cnt - d0, busy);
    end
  endtask
  task automatic test_reset_midop;
    int   lat, d0;
    res_t got, exp;
    logic dn;
    @(negedge clk);
    a = 16'hFE80; b = 16'h0200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++;
    if ({busy, done, mag, neg, sat} !== 20'h0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b done=%b mag=%h neg=%b sat=%b, expected all zero", busy, done, mag, neg, sat);
    end
    repeat (25) @(posedge clk);
    #1 n_chk++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL midop_reset done: %0d pulses after reset, expected 0", done_cnt - d0);
    end
    run_op(16'h0180, 16'h0200, 0, lat, got, dn);
    exp = sb.pop_front();
    n_chk++;
    if (lat !== 19 || got !== exp) begin
      n_fail++;
      $display("FAIL post_reset: lat=%0d mag=%h neg=%b sat=%b, expected lat=19 mag=%h neg=%b sat=%b",
               lat, got.mag, got.neg, got.sat, exp.mag, exp.neg, exp.sat);
    end
  endtask
  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_ignore_start;
    test_reset_midop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
